// File: rtl/siso_frame_rx.sv
// Serial frame receiver: start(0), DATA_W bits LSB-first, optional even parity, stop(1); word out on stop-bit edge.
// One-entry holding register with valid/ready; a good frame arriving while full and not drained is dropped (sticky overrun).
module siso_frame_rx #(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial_in,
  input  logic              out_ready,
  input  logic              clear_err,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    BREAK  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_bad_q, par_bad_d;

  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                frame_err_q, frame_err_d;
  logic                parity_err_q, parity_err_d;
  logic                overrun_q, overrun_d;
  logic                busy_q, busy_d;

  logic                last_bit;
  logic                good_frame;

  assign last_bit = (cnt_q == CNT_W'(DATA_W - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    case (state_q)
      IDLE: begin
        if (!serial_in) begin
          state_d   = DATA;
          cnt_d     = '0;
          par_bad_d = 1'b0;
        end
      end
      DATA: begin
        // Right shift so the first data bit lands in bit 0 after DATA_W edges.
        shift_d = (shift_q >> 1) | (DATA_W'(serial_in) << (DATA_W - 1));
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) begin
          cnt_d   = '0;
          state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        par_bad_d = serial_in ^ (^shift_q);
        state_d   = STOP;
      end
      STOP: begin
        state_d = serial_in ? IDLE : BREAK;
      end
      BREAK: begin
        if (serial_in) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    good_frame   = (state_q == STOP) && serial_in && !par_bad_q;
    frame_err_d  = (state_q == STOP) && !serial_in;
    parity_err_d = (state_q == STOP) && serial_in && par_bad_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    overrun_d    = overrun_q;
    busy_d       = (state_d != IDLE);

    if (good_frame && (!out_valid_q || out_ready)) begin
      out_data_d  = shift_q;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // A new drop on the same edge as clear_err keeps the flag set.
    if (good_frame && out_valid_q && !out_ready) begin
      overrun_d = 1'b1;
    end else if (clear_err) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_siso_frame_rx.sv
// Bench for siso_frame_rx: directed frames plus random traffic against a frame-level model, two parity configurations.
module tb_siso_frame_rx;

  logic clk;
  logic rst;
  logic s0, rdy0, clr0, s1, rdy1, clr1;
  logic [7:0] od0, od1;
  logic ov0, fe0, pe0, or0, bz0;
  logic ov1, fe1, pe1, or1, bz1;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  siso_frame_rx #(.DATA_W(8), .PARITY_EN(0)) dut0 (
    .clk(clk), .rst(rst), .serial_in(s0), .out_ready(rdy0), .clear_err(clr0),
    .out_data(od0), .out_valid(ov0), .frame_err(fe0), .parity_err(pe0),
    .overrun(or0), .busy(bz0)
  );

  siso_frame_rx #(.DATA_W(8), .PARITY_EN(1)) dut1 (
    .clk(clk), .rst(rst), .serial_in(s1), .out_ready(rdy1), .clear_err(clr1),
    .out_data(od1), .out_valid(ov1), .frame_err(fe1), .parity_err(pe1),
    .overrun(or1), .busy(bz1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-level model: ph = -1 idle, -2 waiting for line release, 0..n-1 data bit index,
  // n parity slot (when enabled), n+p stop slot.
  int          ph   [2];
  logic [31:0] wd   [2];
  logic [31:0] e_od [2];
  bit          pb   [2];
  bit          e_ov [2];
  bit          e_fe [2];
  bit          e_pe [2];
  bit          e_or [2];
  bit          e_bz [2];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset(int m);
    ph[m] = -1; wd[m] = 0; e_od[m] = 0; pb[m] = 0;
    e_ov[m] = 0; e_fe[m] = 0; e_pe[m] = 0; e_or[m] = 0; e_bz[m] = 0;
  endtask

  task automatic model_step(int m, logic si, logic rdy, logic clr, int n, int p);
    bit good = 0;
    bit was_full = e_ov[m];
    e_fe[m] = 0;
    e_pe[m] = 0;
    if (ph[m] == -1) begin
      if (!si) begin ph[m] = 0; wd[m] = 0; pb[m] = 0; end
    end else if (ph[m] == -2) begin
      if (si) ph[m] = -1;
    end else if (ph[m] < n) begin
      wd[m] = wd[m] | (32'(si) << ph[m]);
      ph[m]++;
    end else if (p != 0 && ph[m] == n) begin
      pb[m] = (int'(si) != ($countones(wd[m]) % 2));
      ph[m]++;
    end else begin
      if (!si) begin e_fe[m] = 1; ph[m] = -2; end
      else if (pb[m]) begin e_pe[m] = 1; ph[m] = -1; end
      else begin good = 1; ph[m] = -1; end
    end
    if (good && (!was_full || rdy)) begin
      e_od[m] = wd[m];
      e_ov[m] = 1;
    end else if (was_full && rdy) begin
      e_ov[m] = 0;
    end
    if (good && was_full && !rdy) e_or[m] = 1;
    else if (clr) e_or[m] = 0;
    e_bz[m] = (ph[m] != -1);
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, s0, rdy0, clr0, 8, 0);
      model_step(1, s1, rdy1, clr1, 8, 1);
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("d0 out_data", 32'(od0), e_od[0]);
      chk("d0 out_valid", 32'(ov0), 32'(e_ov[0]));
      chk("d0 frame_err", 32'(fe0), 32'(e_fe[0]));
      chk("d0 parity_err", 32'(pe0), 32'(e_pe[0]));
      chk("d0 overrun", 32'(or0), 32'(e_or[0]));
      chk("d0 busy", 32'(bz0), 32'(e_bz[0]));
      chk("d1 out_data", 32'(od1), e_od[1]);
      chk("d1 out_valid", 32'(ov1), 32'(e_ov[1]));
      chk("d1 frame_err", 32'(fe1), 32'(e_fe[1]));
      chk("d1 parity_err", 32'(pe1), 32'(e_pe[1]));
      chk("d1 overrun", 32'(or1), 32'(e_or[1]));
      chk("d1 busy", 32'(bz1), 32'(e_bz[1]));
    end
  end

  task automatic drive_bit(int m, logic b);
    @(negedge clk);
    if (m == 0) s0 = b;
    else s1 = b;
  endtask

  // rdy_stop >= 0 sets rdy0 on the same cycle the stop bit is presented.
  task automatic send_frame(int m, logic [31:0] d, bit pen, bit pbit, bit stopb, int rdy_stop);
    drive_bit(m, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(m, d[i]);
    if (pen) drive_bit(m, pbit);
    drive_bit(m, stopb);
    if (rdy_stop >= 0 && m == 0) rdy0 = (rdy_stop != 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    s0 = 1'b1; rdy0 = 1'b0; clr0 = 1'b0;
    s1 = 1'b1; rdy1 = 1'b0; clr1 = 1'b0;
    #3 rst = 1'b0;
    #1;
    chk("reset out_valid", 32'(ov0), 0);
    chk("reset out_data", 32'(od0), 0);
    chk("reset busy", 32'(bz0), 0);
    chk("reset overrun", 32'(or1), 0);
    #9 rst = 1'b1;
    chk_en = 1;
    repeat (2) @(negedge clk);

    // A5 with consumer ready
    rdy0 = 1'b1;
    send_frame(0, 32'hA5, 0, 0, 1, -1);
    @(negedge clk);
    chk("A5 valid", 32'(ov0), 1);
    chk("A5 data", 32'(od0), 32'hA5);
    chk("A5 model data", e_od[0], 32'hA5);
    chk("A5 frame_err", 32'(fe0), 0);
    @(negedge clk);
    chk("A5 drained", 32'(ov0), 0);

    // Back-to-back frames while stalled: second is dropped
    rdy0 = 1'b0;
    send_frame(0, 32'h3C, 0, 0, 1, -1);
    send_frame(0, 32'hC3, 0, 0, 1, -1);
    @(negedge clk);
    chk("ovr data kept", 32'(od0), 32'h3C);
    chk("ovr flag", 32'(or0), 1);
    chk("ovr model flag", 32'(e_or[0]), 1);
    rdy0 = 1'b1;
    @(negedge clk);
    chk("ovr drained", 32'(ov0), 0);
    rdy0 = 1'b0;
    clr0 = 1'b1;
    @(negedge clk);
    chk("ovr cleared", 32'(or0), 0);
    clr0 = 1'b0;

    // Stop bit 0 followed by held-low line
    rdy0 = 1'b1;
    send_frame(0, 32'h81, 0, 0, 0, -1);
    @(negedge clk);
    chk("brk frame_err", 32'(fe0), 1);
    chk("brk busy", 32'(bz0), 1);
    chk("brk no word", 32'(ov0), 0);
    repeat (4) @(negedge clk);
    chk("brk still busy", 32'(bz0), 1);
    chk("brk pulse once", 32'(fe0), 0);
    s0 = 1'b1;
    @(negedge clk);
    chk("brk released", 32'(bz0), 0);

    // Parity configuration
    rdy1 = 1'b1;
    send_frame(1, 32'h07, 1, 1, 1, -1);
    @(negedge clk);
    chk("par good valid", 32'(ov1), 1);
    chk("par good data", 32'(od1), 32'h07);
    send_frame(1, 32'h07, 1, 0, 1, -1);
    @(negedge clk);
    chk("par bad flag", 32'(pe1), 1);
    chk("par bad model", 32'(e_pe[1]), 1);
    chk("par bad no word", 32'(ov1), 0);

    // Async reset in the middle of a frame, holding register full
    rdy0 = 1'b0;
    send_frame(0, 32'h99, 0, 0, 1, -1);
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("mid rst valid", 32'(ov0), 0);
    chk("mid rst data", 32'(od0), 0);
    chk("mid rst busy", 32'(bz0), 0);
    chk("mid rst errs", {29'd0, fe0, pe0, or0}, 0);
    #4 rst = 1'b1;
    rdy0 = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(0, 32'h5A, 0, 0, 1, -1);
    @(negedge clk);
    chk("post rst data", 32'(od0), 32'h5A);
    chk("post rst valid", 32'(ov0), 1);

    // Drain and load on the same edge
    @(negedge clk);
    rdy0 = 1'b0;
    send_frame(0, 32'h11, 0, 0, 1, -1);
    send_frame(0, 32'h22, 0, 0, 1, 1);
    @(negedge clk);
    chk("swap data", 32'(od0), 32'h22);
    chk("swap valid", 32'(ov0), 1);
    chk("swap no overrun", 32'(or0), 0);
    rdy0 = 1'b0;

    // Random traffic: formed frames on dut0, raw random line on dut1
    fork
      begin
        for (int k = 0; k < 60; k++) begin
          rdy0 = 1'($urandom_range(0, 1));
          clr0 = ($urandom_range(0, 7) == 0);
          send_frame(0, $urandom, 0, 0, ($urandom_range(0, 5) != 0), -1);
          repeat ($urandom_range(0, 2)) drive_bit(0, 1'b1);
        end
        clr0 = 1'b0;
      end
      begin
        for (int j = 0; j < 800; j++) begin
          @(negedge clk);
          s1 = ($urandom_range(0, 3) != 0);
          rdy1 = 1'($urandom_range(0, 1));
          clr1 = ($urandom_range(0, 15) == 0);
        end
      end
    join
    s0 = 1'b1;
    s1 = 1'b1;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
